// File: rtl/apb_master_en_pkg.sv
`default_nettype none
// ============================================================
// Package  : apb_pkg
// Purpose  : shared state encoding and constants for apb_master_en
// Revision : 1.0
// ============================================================
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic APB_RSP_OK  = 1'b0;
  localparam logic APB_RSP_ERR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_master_en_if.sv
`default_nettype none
// ============================================================
// Interface : apb_master_en_if
// Purpose   : request/response handshake plus APB bus signals
// Revision  : 1.0
// ============================================================
interface apb_master_en_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_master_en_wait_timer.sv
`default_nettype none
// ============================================================
// Module   : apb_wait_timer
// Purpose  : counts ACCESS wait strobes, flags expiry at TIMEOUT
// Revision : 1.0
// ============================================================
module apb_wait_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Saturates rather than wraps so a disabled timeout never fires spuriously.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    expire  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q != '1) cnt_d = cnt_inc;
      if ((TIMEOUT != 0) && (cnt_inc == LIMIT)) expire = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/apb_master_en.sv
`default_nettype none
// ============================================================
// Module   : apb_master_en
// Purpose  : APB master sequencer stepping on the pclk_en strobe
// Revision : 1.0
// ============================================================
module apb_master_en
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            pclk_en,
  apb_master_en_if.master bus
);
  apb_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic              lat_write_q, lat_write_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept, timer_clear, timer_tick, timer_expire;

  assign accept     = bus.req_valid && !pend_q;
  assign timer_tick = pclk_en && (state_q == ST_ACCESS) && !bus.pready;

  apb_wait_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk_in (clk_in),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .expire (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_clear = 1'b0;

    if (accept) begin
      pend_d      = 1'b1;
      lat_write_d = bus.req_write;
      lat_addr_d  = bus.req_addr;
      lat_wdata_d = bus.req_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        // An accept on a strobe cycle bypasses the latch and launches directly.
        if (pclk_en && (pend_q || accept)) begin
          state_d     = ST_SETUP;
          timer_clear = 1'b1;
          pwrite_d    = accept ? bus.req_write : lat_write_q;
          paddr_d     = accept ? bus.req_addr  : lat_addr_q;
          pwdata_d    = accept ? bus.req_wdata : lat_wdata_q;
        end
      end
      ST_SETUP: begin
        if (pclk_en) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pclk_en) begin
          if (bus.pready) begin
            state_d     = ST_IDLE;
            pend_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
            rsp_err_d   = bus.pslverr ? APB_RSP_ERR : APB_RSP_OK;
          end else if (timer_expire) begin
            state_d     = ST_IDLE;
            pend_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = APB_RSP_ERR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = !pend_q;
  assign bus.psel      = (state_q != ST_IDLE);
  assign bus.penable   = (state_q == ST_ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_en.sv
`default_nettype none
// ============================================================
// Module   : tb_apb_master_en
// Purpose  : scoreboard bench for apb_master_en, pclk_en every 4th cycle
// Revision : 1.0
// ============================================================
module tb_apb_master_en;
  logic clk;
  logic rst;
  logic rst0;
  logic pclk_en;
  int   cyc;
  int   checks;
  int   errors;
  logic [32:0] sb_q[$];

  apb_master_en_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master_en_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  apb_master_en #(.ADDR_W(32), .DATA_W(32), .TO_W(8), .TIMEOUT(3)) dut (
    .clk_in  (clk),
    .rst     (rst),
    .pclk_en (pclk_en),
    .bus     (bus.master)
  );

  apb_master_en #(.ADDR_W(32), .DATA_W(32), .TO_W(8), .TIMEOUT(0)) dut0 (
    .clk_in  (clk),
    .rst     (rst0),
    .pclk_en (pclk_en),
    .bus     (bus0.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pclk_en = (cyc % 4 == 3);
  endtask

  // Advance through the next strobe edge, driving pready per cycle type.
  task automatic wait_strobe(input logic rdy_strobe, input logic rdy_other);
    logic was;
    for (int i = 0; i < 8; i++) begin
      bus.pready = pclk_en ? rdy_strobe : rdy_other;
      was = pclk_en;
      step();
      if (was) return;
    end
    chk("strobe_wait", 32'(pclk_en), 32'd1);
  endtask

  task automatic align();
    for (int i = 0; i < 8; i++) begin
      if (pclk_en) begin
        step();
        return;
      end
      step();
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input logic push);
    logic acc;
    logic accepted;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      acc = bus.req_ready;
      step();
      accepted = acc;
    end
    bus.req_valid = 1'b0;
    chk("accept", 32'(accepted), 32'd1);
    if (push) sb_q.push_back({exp_rd, exp_err});
  endtask

  // Response monitor: pops expected completions independently of stimulus.
  initial begin
    logic        prev;
    logic [32:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.rsp_valid) begin
          chk("rsp_one_cycle", 32'(prev), 32'd0);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual rsp_valid=1 required rsp_valid=0 rdata=%h", bus.rsp_rdata);
          end else begin
            exp = sb_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, exp[32:1]);
            chk("rsp_err", 32'(bus.rsp_err), 32'(exp[0]));
          end
        end
        prev = bus.rsp_valid;
      end
      if (!rst0) chk("to0_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; rst0 = 1'b1; pclk_en = 1'b0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.prdata = 0; bus.pready = 1; bus.pslverr = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 32'h70; bus0.req_wdata = 0;
    bus0.prdata = 32'h7777_7777; bus0.pready = 0; bus0.pslverr = 0;

    repeat (3) step();
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_paddr", bus.paddr, 32'd0);
    rst = 1'b0; rst0 = 1'b0;

    bus0.req_valid = 1'b1;
    step();
    bus0.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_psel", 32'(bus.psel), 32'd0);
    end

    // Write, zero wait states
    align();
    bus.prdata = 32'h0BAD_F00D;
    issue(1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 1'b0, 1'b1);
    chk("wr_pre_psel", 32'(bus.psel), 32'd0);
    chk("wr_ready_low", 32'(bus.req_ready), 32'd0);
    wait_strobe(1'b1, 1'b1);
    chk("wr_setup_psel", 32'(bus.psel), 32'd1);
    chk("wr_setup_penable", 32'(bus.penable), 32'd0);
    chk("wr_setup_paddr", bus.paddr, 32'h10);
    chk("wr_setup_pwdata", bus.pwdata, 32'hA5A5_0001);
    chk("wr_setup_pwrite", 32'(bus.pwrite), 32'd1);
    wait_strobe(1'b1, 1'b1);
    chk("wr_access_penable", 32'(bus.penable), 32'd1);
    chk("wr_access_paddr", bus.paddr, 32'h10);
    chk("wr_access_pwdata", bus.pwdata, 32'hA5A5_0001);
    wait_strobe(1'b1, 1'b1);
    chk("wr_done_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_done_psel", 32'(bus.psel), 32'd0);
    chk("wr_idle_paddr", bus.paddr, 32'h10);

    // Read, two wait states; pready high off-strobe must be ignored
    align();
    bus.prdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_strobe(1'b1, 1'b1);
    wait_strobe(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_strobe(1'b0, 1'b1);
      chk("rd_wait_penable", 32'(bus.penable), 32'd1);
      chk("rd_wait_valid", 32'(bus.rsp_valid), 32'd0);
    end
    wait_strobe(1'b1, 1'b0);
    chk("rd_done_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_done_psel", 32'(bus.psel), 32'd0);
    step();
    chk("rd_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("rd_rdata_hold", bus.rsp_rdata, 32'hDEAD_BEEF);
    bus.pready = 1'b1;

    // Slave error, then back-to-back accept
    align();
    bus.prdata  = 32'hCAFE_0042;
    bus.pslverr = 1'b1;
    issue(1'b0, 32'h48, 32'h0, 32'hCAFE_0042, 1'b1, 1'b1);
    repeat (3) wait_strobe(1'b1, 1'b1);
    chk("err_done_valid", 32'(bus.rsp_valid), 32'd1);
    chk("err_ready_back", 32'(bus.req_ready), 32'd1);
    bus.pslverr   = 1'b0;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h5555_AAAA;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("next_accepted", 32'(bus.req_ready), 32'd0);
    sb_q.push_back({32'h0, 1'b0});
    repeat (3) wait_strobe(1'b1, 1'b1);
    chk("next_pwdata", bus.pwdata, 32'h5555_AAAA);

    // Timeout with TIMEOUT = 3
    align();
    bus.prdata = 32'h1234_5678;
    issue(1'b0, 32'h50, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_strobe(1'b0, 1'b0);
    wait_strobe(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      wait_strobe(1'b0, 1'b0);
      chk("to_wait_psel", 32'(bus.psel), 32'd1);
      chk("to_wait_valid", 32'(bus.rsp_valid), 32'd0);
    end
    wait_strobe(1'b0, 1'b0);
    chk("to_done_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_done_psel", 32'(bus.psel), 32'd0);
    bus.pready = 1'b1;

    // Accept on a strobe edge, req_valid held through the transfer
    for (int i = 0; i < 8 && !pclk_en; i++) step();
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h1111_2222;
    bus.req_valid = 1'b1;
    step();
    chk("co_setup_psel", 32'(bus.psel), 32'd1);
    chk("co_setup_penable", 32'(bus.penable), 32'd0);
    chk("co_setup_paddr", bus.paddr, 32'h30);
    sb_q.push_back({32'h0, 1'b0});
    bus.req_addr  = 32'h99;
    bus.req_wdata = 32'h0000_9999;
    wait_strobe(1'b1, 1'b1);
    chk("held_ready_low", 32'(bus.req_ready), 32'd0);
    chk("held_paddr", bus.paddr, 32'h30);
    wait_strobe(1'b1, 1'b1);
    chk("held_done_valid", 32'(bus.rsp_valid), 32'd1);
    chk("held_pwdata", bus.pwdata, 32'h1111_2222);
    bus.req_valid = 1'b0;
    repeat (2) wait_strobe(1'b1, 1'b1);
    chk("held_no_second", 32'(bus.psel), 32'd0);

    // Reset during ACCESS
    align();
    issue(1'b0, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_strobe(1'b1, 1'b1);
    wait_strobe(1'b0, 1'b0);
    chk("rstacc_penable", 32'(bus.penable), 32'd1);
    rst = 1'b1;
    step();
    chk("rstacc_psel", 32'(bus.psel), 32'd0);
    chk("rstacc_penable0", 32'(bus.penable), 32'd0);
    chk("rstacc_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstacc_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    repeat (3) wait_strobe(1'b1, 1'b1);
    chk("rstacc_discard", 32'(bus.psel), 32'd0);

    // TIMEOUT = 0 instance must still be in ACCESS
    repeat (6) wait_strobe(1'b1, 1'b1);
    chk("to0_psel", 32'(bus0.psel), 32'd1);
    chk("to0_penable", 32'(bus0.penable), 32'd1);

    repeat (2) step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
